mul_div_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage, directly downstream of the register file. It consumes the RS/RT operand pair and executes MULT, MULTU, DIV and DIVU. Results go to the architectural HI/LO registers, which it owns. It also serves MTHI/MTLO writes and drives a busy flag that the hazard logic uses to stall the pipeline.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mul_div_unit.sv | 149 ++++++++++++++
 tb/tb_mul_div_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, FSM state type, width defaults and small decode helpers.
package mdu_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_ITER = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } mdu_state_t;

    // MULT and DIV are the signed flavours (low opcode bit clear)
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One multiplier/quotient bit is processed per CALC cycle over operand
// magnitudes; signs are reapplied in FIX, which also writes HI/LO.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int ITER = DEF_ITER
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] RSdata_i,
    input  logic [XLEN-1:0] RTdata_i,
    input  logic            HIwrite_i,
    input  logic            LOwrite_i,
    input  logic [XLEN-1:0] Wdata_i,
    output logic [XLEN-1:0] HI_o,
    output logic [XLEN-1:0] LO_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int CW = $clog2(ITER) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(ITER - 1);

    mdu_state_t      r_state;
    logic            r_op_div;
    logic            r_sign_rs;
    logic            r_sign_rt;
    logic            r_div0;
    // Multiplicand magnitude for multiply, divisor magnitude for divide
    logic [XLEN-1:0] r_b;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide: low half holds the dividend shifting out / quotient shifting in.
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN:0]   r_rem;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic            r_busy;
    logic            r_done;

    // Operand magnitudes and signs at accept time (unsigned ops keep raw values)
    logic            w_rs_neg;
    logic            w_rt_neg;
    logic [XLEN-1:0] w_rs_mag;
    logic [XLEN-1:0] w_rt_mag;

    assign w_rs_neg = op_is_signed(op_i) & RSdata_i[XLEN-1];
    assign w_rt_neg = op_is_signed(op_i) & RTdata_i[XLEN-1];
    assign w_rs_mag = w_rs_neg ? (~RSdata_i + 1'b1) : RSdata_i;
    assign w_rt_mag = w_rt_neg ? (~RTdata_i + 1'b1) : RTdata_i;

    // Shift-add step: add multiplicand when the current multiplier LSB is set,
    // then shift the whole accumulator right, carry included.
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Restoring step: bring in the next dividend bit and subtract if it fits.
    logic [XLEN:0] w_div_shift;
    logic [XLEN:0] w_div_sub;
    logic          w_div_ge;

    assign w_div_shift = {r_rem[XLEN-1:0], r_acc[XLEN-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
    assign w_div_sub   = w_div_shift - {1'b0, r_b};

    // Sign fix-up. Divide by zero leaves quotient all ones and the remainder
    // equal to the dividend magnitude, so restoring the dividend sign returns
    // the original RS value; LO is forced to all ones regardless of signs.
    logic              w_sign_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;

    assign w_sign_diff = r_sign_rs ^ r_sign_rt;
    assign w_prod      = w_sign_diff ? (~r_acc + 1'b1) : r_acc;
    assign w_quo       = r_div0      ? {XLEN{1'b1}} :
                         w_sign_diff ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
    assign w_rem       = r_sign_rs   ? (~r_rem[XLEN-1:0] + 1'b1) : r_rem[XLEN-1:0];

    // Control FSM, iteration datapath and HI/LO ownership in one register block
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_IDLE;
            r_op_div  <= 1'b0;
            r_sign_rs <= 1'b0;
            r_sign_rt <= 1'b0;
            r_div0    <= 1'b0;
            r_b       <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (HIwrite_i) r_hi <= Wdata_i;
                    if (LOwrite_i) r_lo <= Wdata_i;
                    if (start_i) begin
                        r_op_div  <= op_is_div(op_i);
                        r_sign_rs <= w_rs_neg;
                        r_sign_rt <= w_rt_neg;
                        r_div0    <= op_is_div(op_i) && (RTdata_i == '0);
                        r_b       <= op_is_div(op_i) ? w_rt_mag : w_rs_mag;
                        r_acc     <= {{XLEN{1'b0}}, (op_is_div(op_i) ? w_rs_mag : w_rt_mag)};
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (r_op_div) begin
                        r_rem            <= w_div_ge ? w_div_sub : w_div_shift;
                        r_acc[XLEN-1:0]  <= {r_acc[XLEN-2:0], w_div_ge};
                    end else begin
                        r_acc <= w_mul_next;
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_hi    <= r_op_div ? w_rem : w_prod[2*XLEN-1:XLEN];
                    r_lo    <= r_op_div ? w_quo : w_prod[XLEN-1:0];
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign HI_o   = r_hi;
    assign LO_o   = r_lo;
    assign busy_o = r_busy;
    assign done_o = r_done;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected HI/LO and the
// cycle on which done_o must appear; a negedge monitor pops on each done_o.
module tb_mul_div_unit;

    logic        clk;
    logic        rst_n_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] RSdata_i;
    logic [31:0] RTdata_i;
    logic        HIwrite_i;
    logic        LOwrite_i;
    logic [31:0] Wdata_i;
    logic [31:0] HI_o;
    logic [31:0] LO_o;
    logic        busy_o;
    logic        done_o;

    mul_div_unit #(.XLEN(32), .ITER(32)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n_i),
        .start_i   (start_i),
        .op_i      (op_i),
        .RSdata_i  (RSdata_i),
        .RTdata_i  (RTdata_i),
        .HIwrite_i (HIwrite_i),
        .LOwrite_i (LOwrite_i),
        .Wdata_i   (Wdata_i),
        .HI_o      (HI_o),
        .LO_o      (LO_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("[TB] ok %s = 0x%08h", name, act);
        end
    endtask

    // Monitor: every done_o pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n_i && done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done_o at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, ".HI"}, HI_o, e.hi);
                chk({e.name, ".LO"}, LO_o, e.lo);
                chk({e.name, ".cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issue one operation and wait until its result is due (E33 + half cycle)
    task automatic issue(input string nm, input logic [1:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        @(negedge clk);
        start_i  = 1'b1;
        op_i     = op;
        RSdata_i = rs;
        RTdata_i = rt;
        e.name = nm; e.hi = ehi; e.lo = elo; e.cyc = cyc + 34;
        exp_q.push_back(e);
        @(negedge clk);
        start_i = 1'b0;
        repeat (33) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        rst_n_i   = 1'b0;
        start_i   = 1'b0;
        op_i      = 2'b00;
        RSdata_i  = '0;
        RTdata_i  = '0;
        HIwrite_i = 1'b0;
        LOwrite_i = 1'b0;
        Wdata_i   = '0;

        repeat (2) @(negedge clk);
        chk("reset.HI",   HI_o, 32'h0);
        chk("reset.LO",   LO_o, 32'h0);
        chk("reset.busy", {31'b0, busy_o}, 32'h0);
        chk("reset.done", {31'b0, done_o}, 32'h0);
        rst_n_i = 1'b1;

        issue("mult_m1_m1",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
        issue("multu_max_2",  2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE);
        issue("div_m7_2",     2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue("divu_m7_2",    2'b11, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC);
        issue("div_by_zero",  2'b10, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF);
        issue("div_neg_by_0", 2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
        issue("div_min_m1",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        issue("mult_m3_5",    2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
        issue("div_7_m2",     2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        issue("divu_100_7",   2'b11, 32'd100,      32'd7,        32'h00000002, 32'd14);

        // MTLO alone, then MTHI and MTLO together, in IDLE
        @(negedge clk);
        LOwrite_i = 1'b1; Wdata_i = 32'hA5A5A5A5;
        @(negedge clk);
        LOwrite_i = 1'b0;
        chk("mtlo.LO", LO_o, 32'hA5A5A5A5);
        chk("mtlo.HI_kept", HI_o, 32'h00000002);
        HIwrite_i = 1'b1; LOwrite_i = 1'b1; Wdata_i = 32'h0F0F0F0F;
        @(negedge clk);
        HIwrite_i = 1'b0; LOwrite_i = 1'b0;
        chk("mtboth.HI", HI_o, 32'h0F0F0F0F);
        chk("mtboth.LO", LO_o, 32'h0F0F0F0F);

        // start and MTHI during a busy op are both ignored
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b01; RSdata_i = 32'hFFFFFFFF; RTdata_i = 32'h2;
        e.name = "busy_ignore"; e.hi = 32'h1; e.lo = 32'hFFFFFFFE; e.cyc = cyc + 34;
        exp_q.push_back(e);
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_ignore.busy", {31'b0, busy_o}, 32'h1);
        chk("busy_ignore.HI_hold", HI_o, 32'h0F0F0F0F);
        chk("busy_ignore.LO_hold", LO_o, 32'h0F0F0F0F);
        start_i = 1'b1; op_i = 2'b11; RSdata_i = 32'd9; RTdata_i = 32'd3;
        HIwrite_i = 1'b1; Wdata_i = 32'hDEADBEEF;
        @(negedge clk);
        start_i = 1'b0; HIwrite_i = 1'b0;
        chk("busy_ignore.HI_nowrite", HI_o, 32'h0F0F0F0F);
        repeat (28) @(negedge clk);

        // start together with MTHI in IDLE: write lands now, result overwrites later
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b01; RSdata_i = 32'd6; RTdata_i = 32'd7;
        HIwrite_i = 1'b1; Wdata_i = 32'h00012345;
        e.name = "start_mthi"; e.hi = 32'h0; e.lo = 32'd42; e.cyc = cyc + 34;
        exp_q.push_back(e);
        @(negedge clk);
        start_i = 1'b0; HIwrite_i = 1'b0;
        chk("start_mthi.HI_early", HI_o, 32'h00012345);
        repeat (33) @(negedge clk);

        // Reset during a DIV discards it and clears outputs immediately
        @(negedge clk);
        HIwrite_i = 1'b1; Wdata_i = 32'h00000055;
        @(negedge clk);
        HIwrite_i = 1'b0;
        start_i = 1'b1; op_i = 2'b10; RSdata_i = 32'd100; RTdata_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_mid.busy_before", {31'b0, busy_o}, 32'h1);
        @(posedge clk);
        #2 rst_n_i = 1'b0;
        #1;
        chk("rst_mid.busy", {31'b0, busy_o}, 32'h0);
        chk("rst_mid.HI",   HI_o, 32'h0);
        chk("rst_mid.LO",   LO_o, 32'h0);
        chk("rst_mid.done", {31'b0, done_o}, 32'h0);
        @(negedge clk);
        rst_n_i = 1'b1;
        repeat (30) @(negedge clk);

        issue("mult_3_4", 2'b00, 32'd3, 32'd4, 32'h0, 32'd12);

        repeat (5) @(negedge clk);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s.missing_done: got no done_o expected done at cycle %0d", e.name, e.cyc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
